// File: rtl/bus_dev_fifo.sv
// bus_dev_fifo: per-device source FIFO feeding one driver slot of the
// parallel bus. Words written by the agent side are presented
// first-word-fall-through on D_pop with a pndng/pop handshake toward
// the bus. Occupancy and sticky overflow/underflow flags are exported
// for scoreboarding.
module bus_dev_fifo #(
  parameter int bits  = 32,
  parameter int depth = 16,
  parameter int id    = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [bits-1:0]            wr_data,
  output logic                       full,
  output logic                       pndng,
  input  logic                       pop,
  output logic [bits-1:0]            D_pop,
  output logic [$clog2(depth+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int cw = $clog2(depth + 1);
  localparam int pw = $clog2(depth);

  localparam logic [cw-1:0] depth_c = cw'(depth);
  localparam logic [pw-1:0] last_c  = pw'(depth - 1);

  logic [bits-1:0] mem [depth];
  logic [pw-1:0]   wr_ptr;
  logic [pw-1:0]   rd_ptr;
  logic [cw-1:0]   cnt;
  logic            pop_ok;
  logic            wr_ok;
  logic [cw-1:0]   cnt_next;

  // Handshake qualification: a pop needs a stored word; a write needs a
  // free slot, or the slot being freed by a simultaneous pop.
  always_comb begin
    pop_ok = pop && (cnt != '0);
    wr_ok  = wr_en && ((cnt < depth_c) || pop_ok);
  end

  // Occupancy next-state: both or neither leaves the count unchanged.
  always_comb begin
    // NOTE: default assigned first so every path drives cnt_next; a missing
    // branch in combinational logic would otherwise infer a latch.
    cnt_next = cnt;
    unique case ({wr_ok, pop_ok})
      2'b10:   cnt_next = cnt + 1'b1;
      2'b01:   cnt_next = cnt - 1'b1;
      default: cnt_next = cnt;
    endcase
  end

  // Pointer, count and sticky-flag state; reset wins over any handshake.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments for all registered state so every
    // register samples the pre-edge values regardless of statement order.
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok)
        wr_ptr <= (wr_ptr == last_c) ? '0 : wr_ptr + 1'b1;
      if (pop_ok)
        rd_ptr <= (rd_ptr == last_c) ? '0 : rd_ptr + 1'b1;
      cnt <= cnt_next;
      if (wr_en && !wr_ok)
        overflow <= 1'b1;
      if (pop && (cnt == '0))
        underflow <= 1'b1;
    end
  end

  // Storage array write port; a write coinciding with reset is discarded.
  always_ff @(posedge clock) begin
    // NOTE: the array itself is not reset; its contents are only visible
    // through D_pop, which is masked whenever the FIFO is empty.
    if (!reset && wr_ok)
      mem[wr_ptr] <= wr_data;
  end

  // Status outputs decode registered state only; head word is masked.
  always_comb begin
    count = cnt;
    pndng = (cnt != '0);
    full  = (cnt == depth_c);
    D_pop = pndng ? mem[rd_ptr] : '0;
  end

`ifndef SYNTHESIS
  // Structural invariants of the occupancy encoding.
  always @(posedge clock) begin
    if (!reset) begin
      assert (cnt <= depth_c)
        else $error("bus_dev_fifo %0d: count exceeds depth", id);
      assert (pndng == (cnt != '0))
        else $error("bus_dev_fifo %0d: pndng inconsistent with count", id);
      assert (full == (cnt == depth_c))
        else $error("bus_dev_fifo %0d: full inconsistent with count", id);
    end
  end
`endif

endmodule

// File: tb/tb_bus_dev_fifo.sv
// Directed testbench for bus_dev_fifo at bits=16, depth=4.
module tb_bus_dev_fifo;

  localparam int bits  = 16;
  localparam int depth = 4;

  logic            clock = 1'b0;
  logic            reset;
  logic            wr_en;
  logic [bits-1:0] wr_data;
  logic            full;
  logic            pndng;
  logic            pop;
  logic [bits-1:0] D_pop;
  logic [2:0]      count;
  logic            overflow;
  logic            underflow;

  int n_checks = 0;
  int n_pass   = 0;

  bus_dev_fifo #(.bits(bits), .depth(depth), .id(3)) dut (
    .clock     (clock),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .pndng     (pndng),
    .pop       (pop),
    .D_pop     (D_pop),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Apply one cycle of inputs, then sample 1 ns after the rising edge.
  task automatic cyc(input logic w, input logic [bits-1:0] d, input logic p);
    wr_en   = w;
    wr_data = d;
    pop     = p;
    @(posedge clock);
    #1;
    wr_en = 1'b0;
    pop   = 1'b0;
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_data = '0; pop = 1'b0;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    reset = 1'b0;
    check("rst_count", 32'(count), 0);
    check("rst_pndng", 32'(pndng), 0);
    check("rst_full",  32'(full),  0);
    check("rst_dpop",  32'(D_pop), 0);
    check("rst_ovf",   32'(overflow), 0);
    check("rst_udf",   32'(underflow), 0);

    // Three writes, FWFT head after the first edge, then ordered drain.
    cyc(1, 16'h0001, 0);
    check("t1_pndng1", 32'(pndng), 1);
    check("t1_head1",  32'(D_pop), 16'h0001);
    cyc(1, 16'h0002, 0);
    cyc(1, 16'h0003, 0);
    check("t1_count3", 32'(count), 3);
    check("t1_head",   32'(D_pop), 16'h0001);
    cyc(0, 0, 1);
    check("t1_pop1",   32'(D_pop), 16'h0002);
    cyc(0, 0, 1);
    check("t1_pop2",   32'(D_pop), 16'h0003);
    cyc(0, 0, 1);
    check("t1_empty",  32'(pndng), 0);
    check("t1_dpop0",  32'(D_pop), 0);
    check("t1_udf",    32'(underflow), 0);

    // Fill, then a dropped write while full.
    for (int i = 0; i < 4; i++) cyc(1, 16'(16'hA0 + i), 0);
    check("t2_full",   32'(full),  1);
    check("t2_count",  32'(count), 4);
    check("t2_ovf0",   32'(overflow), 0);
    cyc(1, 16'h00FF, 0);
    check("t2_ovf",    32'(overflow), 1);
    check("t2_count4", 32'(count), 4);
    check("t2_head",   32'(D_pop), 16'h00A0);

    // Simultaneous write and pop while full.
    cyc(1, 16'h00B0, 1);
    check("t3_head",   32'(D_pop), 16'h00A1);
    check("t3_count",  32'(count), 4);
    check("t3_full",   32'(full),  1);
    cyc(0, 0, 1);
    check("t3_d2",     32'(D_pop), 16'h00A2);
    cyc(0, 0, 1);
    check("t3_d3",     32'(D_pop), 16'h00A3);
    cyc(0, 0, 1);
    check("t3_b0",     32'(D_pop), 16'h00B0);
    cyc(0, 0, 1);
    check("t3_empty",  32'(pndng), 0);
    check("t3_udf",    32'(underflow), 0);

    // Pop while empty together with a write.
    cyc(1, 16'h0055, 1);
    check("t4_udf",    32'(underflow), 1);
    check("t4_count",  32'(count), 1);
    check("t4_pndng",  32'(pndng), 1);
    check("t4_head",   32'(D_pop), 16'h0055);
    cyc(0, 0, 1);
    check("t4_empty",  32'(count), 0);

    // Interleaved traffic 0..9 forcing the pointers to wrap twice.
    cyc(1, 16'd0, 0);
    for (int i = 1; i < 10; i++) begin
      check($sformatf("t5_seq%0d", i - 1), 32'(D_pop), 32'(i - 1));
      cyc(1, 16'(i), 1);
      check($sformatf("t5_cnt%0d", i), 32'(count), 1);
    end
    check("t5_seq9",   32'(D_pop), 9);
    cyc(0, 0, 1);
    check("t5_empty",  32'(pndng), 0);

    // Mid-operation reset with a coincident write.
    cyc(1, 16'h0011, 0);
    cyc(1, 16'h0022, 0);
    cyc(1, 16'h0033, 0);
    check("t6_pre",    32'(count), 3);
    reset = 1'b1;
    cyc(1, 16'h0044, 0);
    reset = 1'b0;
    check("t6_count",  32'(count), 0);
    check("t6_pndng",  32'(pndng), 0);
    check("t6_dpop",   32'(D_pop), 0);
    check("t6_ovf",    32'(overflow), 0);
    check("t6_udf",    32'(underflow), 0);
    cyc(0, 0, 0);
    check("t6_nostore", 32'(count), 0);
    cyc(1, 16'h0066, 0);
    check("t6_fresh",  32'(D_pop), 16'h0066);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
